// File: rtl/bus_rr_arbiter.sv
// Multi-bus packet arbiter: one two-state engine per bus pops a granted FIFO head,
// then pushes it to its unicast/broadcast receivers, or drops and counts it.
module bus_rr_engine #(
  parameter int          DRVRS = 6,
  parameter int          PKT_W = 16,
  parameter logic [7:0]  BCAST = 8'hFF,
  parameter bit          RR    = 1'b1,
  parameter int          CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DRVRS-1:0]             pndng,
  input  logic [DRVRS-1:0][PKT_W-1:0]  d_pop,
  output logic [DRVRS-1:0]             pop,
  output logic [DRVRS-1:0]             push,
  output logic [PKT_W-1:0]             d_push,
  output logic [CNT_W-1:0]             drop_cnt
);
  localparam int PW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  typedef enum logic {IDLE, XFER} state_e;
  state_e state_q, state_d;

  logic [PW-1:0]    ptr_q, ptr_d, src_q, src_d, gnt;
  logic             gnt_vld;
  logic [PKT_W-1:0] pkt_q, pkt_d, dpush_q, dpush_d;
  logic [DRVRS-1:0] pop_q, pop_d, push_q, push_d, mask;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [7:0]       dest;

  // Round-robin scans from ptr+1 with wrap; fixed priority scans from 0.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < DRVRS; i++) begin
      idx = RR ? int'(ptr_q) + 1 + i : i;
      if (idx >= DRVRS) idx = idx - DRVRS;
      if (!gnt_vld && pndng[PW'(idx)]) begin
        gnt     = PW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  assign dest = pkt_q[PKT_W-1 -: 8];

  always_comb begin
    if (dest == BCAST)                                mask = ~(DRVRS'(1) << src_q);
    else if (int'(dest) < DRVRS && dest != 8'(src_q)) mask = DRVRS'(1) << dest;
    else                                              mask = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (gnt_vld) state_d = XFER;
      XFER: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_d   = '0;
    push_d  = '0;
    pkt_d   = pkt_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    dpush_d = dpush_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        pop_d = DRVRS'(1) << gnt;
        pkt_d = d_pop[gnt];
        src_d = gnt;
        if (RR) ptr_d = gnt;
      end
      XFER: begin
        push_d  = mask;
        dpush_d = pkt_q;
        if (mask == '0 && drop_q != '1) drop_d = drop_q + CNT_W'(1);
      end
    endcase
  end

  // Pointer resets to the last device so the first round-robin grant is device 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q   <= '0;
      push_q  <= '0;
      pkt_q   <= '0;
      src_q   <= '0;
      ptr_q   <= PW'(DRVRS - 1);
      dpush_q <= '0;
      drop_q  <= '0;
    end else begin
      pop_q   <= pop_d;
      push_q  <= push_d;
      pkt_q   <= pkt_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      dpush_q <= dpush_d;
      drop_q  <= drop_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign d_push   = dpush_q;
  assign drop_cnt = drop_q;
endmodule

module bus_rr_arbiter #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 6,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int         arb_mode  = 1,
  parameter int         cnt_w     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [bits*drvrs-1:0]              pndng,
  input  logic [bits*drvrs*pckg_sz-1:0]      D_pop,
  output logic [bits*drvrs-1:0]              pop,
  output logic [bits*drvrs-1:0]              push,
  output logic [bits*drvrs*pckg_sz-1:0]      D_push,
  output logic [bits*cnt_w-1:0]              drop_cnt
);
  for (genvar b = 0; b < bits; b++) begin : g_bus
    logic [drvrs-1:0][pckg_sz-1:0] dpop_b;
    logic [pckg_sz-1:0]            dpush_b;

    assign dpop_b = D_pop[b*drvrs*pckg_sz +: drvrs*pckg_sz];

    bus_rr_engine #(
      .DRVRS(drvrs), .PKT_W(pckg_sz), .BCAST(broadcast),
      .RR(arb_mode != 0), .CNT_W(cnt_w)
    ) u_eng (
      .clk      (clk),
      .rst_n    (reset),
      .pndng    (pndng[b*drvrs +: drvrs]),
      .d_pop    (dpop_b),
      .pop      (pop[b*drvrs +: drvrs]),
      .push     (push[b*drvrs +: drvrs]),
      .d_push   (dpush_b),
      .drop_cnt (drop_cnt[b*cnt_w +: cnt_w])
    );

    for (genvar d = 0; d < drvrs; d++) begin : g_dev
      assign D_push[(b*drvrs+d)*pckg_sz +: pckg_sz] = dpush_b;
    end
  end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: a 2-bus round-robin/4-bit-counter instance and a 1-bus
// fixed-priority instance, checked every cycle against a transaction-level model.
module tb_bus_rr_arbiter;
  localparam int N = 6;
  localparam int W = 16;
  localparam int U = 3;   // units 0,1 = buses of dut_a, unit 2 = dut_b

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2*N-1:0]   pndA, popA, pushA;
  logic [2*N*W-1:0] dpopA, dpushA;
  logic [7:0]       dropA;
  logic [N-1:0]     pndB, popB, pushB;
  logic [N*W-1:0]   dpopB, dpushB;
  logic [15:0]      dropB;

  bus_rr_arbiter #(.bits(2), .drvrs(N), .pckg_sz(W), .broadcast(8'hFF), .arb_mode(1), .cnt_w(4)) dut_a (
    .clk(clk), .reset(rst_n), .pndng(pndA), .D_pop(dpopA),
    .pop(popA), .push(pushA), .D_push(dpushA), .drop_cnt(dropA));

  bus_rr_arbiter #(.bits(1), .drvrs(N), .pckg_sz(W), .broadcast(8'hFF), .arb_mode(0), .cnt_w(16)) dut_b (
    .clk(clk), .reset(rst_n), .pndng(pndB), .D_pop(dpopB),
    .pop(popB), .push(pushB), .D_push(dpushB), .drop_cnt(dropB));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- accessors ----------------
  function automatic logic [N-1:0] req_of(input int u);
    return (u < 2) ? pndA[u*N +: N] : pndB;
  endfunction
  function automatic logic [W-1:0] dat_of(input int u, input int d);
    return (u < 2) ? dpopA[(u*N+d)*W +: W] : dpopB[d*W +: W];
  endfunction
  function automatic logic [N-1:0] pop_of(input int u);
    return (u < 2) ? popA[u*N +: N] : popB;
  endfunction
  function automatic logic [N-1:0] push_of(input int u);
    return (u < 2) ? pushA[u*N +: N] : pushB;
  endfunction
  function automatic logic [W-1:0] dpush_of(input int u, input int d);
    return (u < 2) ? dpushA[(u*N+d)*W +: W] : dpushB[d*W +: W];
  endfunction
  function automatic int drop_of(input int u);
    return (u < 2) ? int'(dropA[u*4 +: 4]) : int'(dropB);
  endfunction

  task automatic set_dev(input int u, input int d, input logic on, input logic [W-1:0] pkt);
    if (u < 2) begin
      pndA[u*N+d] = on;
      dpopA[(u*N+d)*W +: W] = pkt;
    end else begin
      pndB[d] = on;
      dpopB[d*W +: W] = pkt;
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(input logic [N-1:0] req, input int ptr, input bit rr);
    for (int k = 1; k <= N; k++) begin
      int d;
      d = rr ? (ptr + k) % N : k - 1;
      if (req[d]) return d;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] dmask(input logic [W-1:0] p, input int s);
    int dst;
    dst = int'(p[W-1 -: 8]);
    if (dst == 255) return ~(N'(1) << s);
    if (dst < N && dst != s) return N'(1) << dst;
    return '0;
  endfunction

  logic [N-1:0] m_pop[U], m_push[U];
  logic [W-1:0] m_dp[U], m_pkt[U];
  int           m_src[U], m_ptr[U], m_drop[U];
  bit           m_busy[U];

  always @(posedge clk or negedge rst_n) begin
    int g;
    int cap;
    logic [N-1:0] m;
    if (!rst_n) begin
      for (int u = 0; u < U; u++) begin
        m_busy[u] <= 1'b0; m_pop[u] <= '0; m_push[u] <= '0; m_dp[u] <= '0;
        m_pkt[u] <= '0; m_src[u] <= 0; m_ptr[u] <= N - 1; m_drop[u] <= 0;
      end
    end else begin
      for (int u = 0; u < U; u++) begin
        cap = (u < 2) ? 15 : 65535;
        if (!m_busy[u]) begin
          m_push[u] <= '0;
          g = pick(req_of(u), m_ptr[u], u < 2);
          if (g >= 0) begin
            m_pop[u]  <= N'(1) << g;
            m_pkt[u]  <= dat_of(u, g);
            m_src[u]  <= g;
            m_busy[u] <= 1'b1;
            if (u < 2) m_ptr[u] <= g;
          end else begin
            m_pop[u] <= '0;
          end
        end else begin
          m = dmask(m_pkt[u], m_src[u]);
          m_pop[u]  <= '0;
          m_push[u] <= m;
          m_dp[u]   <= m_pkt[u];
          if (m == '0 && m_drop[u] < cap) m_drop[u] <= m_drop[u] + 1;
          m_busy[u] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < U; u++) begin
      chk($sformatf("pop u%0d", u), pop_of(u), m_pop[u]);
      chk($sformatf("push u%0d", u), push_of(u), m_push[u]);
      chk($sformatf("drop u%0d", u), drop_of(u), m_drop[u]);
      for (int d = 0; d < N; d++)
        chk($sformatf("dpush u%0d d%0d", u, d), dpush_of(u, d), m_dp[u]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_all();
    pndA = '0;
    pndB = '0;
  endtask

  // One packet from unit u device d; checks pop at t+1 and push at t+2.
  task automatic one_pkt(input string nm, input int u, input int d, input logic [W-1:0] pkt,
                         input logic [N-1:0] exp_push);
    set_dev(u, d, 1'b1, pkt);
    @(negedge clk);
    @(negedge clk);
    chk({nm, " pop"}, pop_of(u), N'(1) << d);
    tick();
    set_dev(u, d, 1'b0, pkt);
    @(negedge clk);
    chk({nm, " push"}, push_of(u), exp_push);
    chk({nm, " dpush"}, dpush_of(u, N-1), pkt);
    tick(3);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rr_exp[6];

  initial begin
    rr_exp = '{6'b000001, 6'b000100, 6'b100000, 6'b000001, 6'b000100, 6'b100000};
    rst_n = 1'b0;
    pndA = '1;
    pndB = '1;
    for (int d = 0; d < N; d++) begin
      set_dev(0, d, 1'b1, {8'((d + 1) % N), 8'(d)});
      set_dev(1, d, 1'b1, {8'((d + 1) % N), 8'(d)});
      set_dev(2, d, 1'b1, {8'((d + 1) % N), 8'(d)});
    end

    // reset held with everything pending
    repeat (2) begin
      @(negedge clk);
      chk("rst popA", popA, '0);   chk("rst pushA", pushA, '0);
      chk("rst dpushA", dpushA, '0); chk("rst dropA", dropA, '0);
      chk("rst popB", popB, '0);   chk("rst pushB", pushB, '0);
      chk("rst dpushB", dpushB, '0); chk("rst dropB", dropB, '0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first cycle pop", popA, '0);
    @(negedge clk);
    chk("first popA", popA, 12'b000001_000001);
    chk("first popB", popB, 6'b000001);
    tick();
    clear_all();
    tick(3);

    // unicast, continuous pending
    set_dev(2, 2, 1'b1, 16'h0455);
    @(negedge clk);
    @(negedge clk);
    chk("uni pop t+1", popB, 6'b000100);
    @(negedge clk);
    chk("uni push t+2", pushB, 6'b010000);
    chk("uni dpush t+2", dpushB[0 +: W], 16'h0455);
    chk("uni pop idle t+2", popB, '0);
    @(negedge clk);
    chk("uni pop t+3", popB, 6'b000100);
    tick();
    clear_all();
    tick(3);

    one_pkt("bcast", 2, 3, 16'hFFAA, 6'b110111);
    one_pkt("bad dest", 2, 0, 16'h0912, 6'b000000);
    one_pkt("self dest", 2, 1, 16'h0100, 6'b000000);
    chk("dropB two", dropB, 16'd2);

    // round-robin vs fixed priority, with both buses of dut_a active
    rst_pulse();
    set_dev(0, 0, 1'b1, 16'h0111); set_dev(0, 2, 1'b1, 16'h0322); set_dev(0, 5, 1'b1, 16'h0033);
    set_dev(2, 0, 1'b1, 16'h0111); set_dev(2, 2, 1'b1, 16'h0322); set_dev(2, 5, 1'b1, 16'h0033);
    set_dev(1, 4, 1'b1, 16'h0100);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr pop %0d", k), popA[N-1:0], rr_exp[k]);
      chk($sformatf("fp pop %0d", k), popB, 6'b000001);
      chk($sformatf("bus1 pop %0d", k), popA[2*N-1:N], 6'b010000);
      @(negedge clk);
      if (k == 0) chk("two-bus push", pushA, 12'b000010_000010);
    end
    tick();
    clear_all();
    tick(3);

    // drop counter saturation on bus 1 of dut_a
    set_dev(1, 3, 1'b1, 16'h0955);
    tick(42);
    clear_all();
    tick(3);
    chk("sat dropA", dropA, 8'hF0);

    // randomized traffic with one asynchronous reset mid-run
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (cyc == 1500) rst_n = 1'b0;
      if (cyc == 1502) rst_n = 1'b1;
      for (int u = 0; u < U; u++)
        for (int d = 0; d < N; d++) begin
          logic [7:0] dst;
          int r;
          r = int'($urandom_range(0, 9));
          if (r <= 5)      dst = 8'(r);
          else if (r == 6 || r == 8) dst = 8'hFF;
          else             dst = 8'($urandom_range(0, 255));
          set_dev(u, d, 1'($urandom_range(0, 1)), {dst, 8'($urandom_range(0, 255))});
        end
    end
    tick();
    clear_all();
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
